// File: rtl/hdu_bank_scheduler.sv
// Bank-conflict-free issue scheduler: captures a batch of up to 8 lane addresses
// and issues them over as many cycles as needed so no two lanes per cycle share a bank.
module hdu_bank_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int Bank_Num_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_valid,
    input  logic [8*ADDR_W-1:0]   in_addr,
    output logic                  in_ready,
    output logic [7:0]            out_valid,
    output logic [8*ADDR_W-1:0]   out_addr,
    input  logic                  out_ready,
    output logic [31:0]           conflict_cnt,
    output logic [31:0]           batch_cnt
);

    localparam int LANES = 8;

    logic [7:0]             pending_reg;
    logic [8*ADDR_W-1:0]    addr_reg;
    logic [2:0]             ptr_reg;
    logic [7:0]             out_valid_reg;
    logic [ADDR_W-1:0]      out_addr_reg [LANES];
    logic [31:0]            conflict_cnt_reg;
    logic [31:0]            batch_cnt_reg;

    logic [Bank_Num_W-1:0]  bank [LANES];
    logic [7:0][7:0]        same_bank;
    logic [7:0]             grant;
    logic [7:0]             issue_mask;
    logic [7:0]             pending_next;
    logic                   adv;
    logic                   capture;

    genvar gi, gj;

    // Bank index of each captured lane and the pairwise bank-equality matrix.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            assign bank[gi] = addr_reg[gi*ADDR_W +: Bank_Num_W];
        end
        for (gi = 0; gi < LANES; gi++) begin : g_same_row
            for (gj = 0; gj < LANES; gj++) begin : g_same_col
                assign same_bank[gi][gj] = (bank[gi] == bank[gj]);
            end
        end
    endgenerate

    // Scan from ptr; a pending lane is granted unless an earlier-scanned grant owns its bank.
    always_comb begin : grant_scan
        logic [2:0] lane;
        logic [2:0] prev;
        logic       blocked;
        grant   = '0;
        lane    = '0;
        prev    = '0;
        blocked = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane    = ptr_reg + 3'(k);
            blocked = 1'b0;
            for (int p = 0; p < k; p++) begin
                prev = ptr_reg + 3'(p);
                if (grant[prev] && same_bank[prev][lane]) begin
                    blocked = 1'b1;
                end
            end
            if (pending_reg[lane] && !blocked) begin
                grant[lane] = 1'b1;
            end
        end
    end

    assign adv          = out_ready || (out_valid_reg == 8'h00);
    assign issue_mask   = adv ? grant : 8'h00;
    assign pending_next = pending_reg & ~issue_mask;
    assign in_ready     = (pending_next == 8'h00);
    assign capture      = in_ready && (|in_valid);

    // A capture reloads pending; the lanes issued on that edge came from the old batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg      <= '0;
            addr_reg         <= '0;
            ptr_reg          <= '0;
            out_valid_reg    <= '0;
            conflict_cnt_reg <= '0;
            batch_cnt_reg    <= '0;
        end else begin
            if (adv) begin
                out_valid_reg <= grant;
                if (|grant) begin
                    ptr_reg <= ptr_reg + 3'd1;
                    if (|pending_next) begin
                        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
                    end
                end
            end
            if (capture) begin
                pending_reg   <= in_valid;
                addr_reg      <= in_addr;
                batch_cnt_reg <= batch_cnt_reg + 32'd1;
            end else begin
                pending_reg <= pending_next;
            end
        end
    end

    // Lanes not granted keep their last issued address.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_out_addr
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_addr_reg[gi] <= '0;
                end else if (issue_mask[gi]) begin
                    out_addr_reg[gi] <= addr_reg[gi*ADDR_W +: ADDR_W];
                end
            end
            assign out_addr[gi*ADDR_W +: ADDR_W] = out_addr_reg[gi];
        end
    endgenerate

    assign out_valid    = out_valid_reg;
    assign conflict_cnt = conflict_cnt_reg;
    assign batch_cnt    = batch_cnt_reg;

endmodule

// File: tb/tb_hdu_bank_scheduler.sv
// Scoreboard bench for hdu_bank_scheduler: expected issue groups are queued as
// batches are driven and popped as the scheduler issues them.
module tb_hdu_bank_scheduler;

    localparam int AW = 16;
    localparam int BW = 5;

    typedef struct packed {
        logic [7:0]      mask;
        logic [8*AW-1:0] addr;
    } issue_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      in_valid = '0;
    logic [8*AW-1:0] in_addr = '0;
    logic            in_ready;
    logic [7:0]      out_valid;
    logic [8*AW-1:0] out_addr;
    logic            out_ready = 1'b0;
    logic [31:0]     conflict_cnt;
    logic [31:0]     batch_cnt;

    issue_t sb_q[$];
    int     n_pass  = 0;
    int     n_total = 0;

    always #5 clk = ~clk;

    hdu_bank_scheduler #(.ADDR_W(AW), .Bank_Num_W(BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_addr      (in_addr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_addr     (out_addr),
        .out_ready    (out_ready),
        .conflict_cnt (conflict_cnt),
        .batch_cnt    (batch_cnt)
    );

    function automatic logic [8*AW-1:0] lane_bits(input logic [7:0] m);
        logic [8*AW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[i*AW +: AW] = '1;
        end
        return r;
    endfunction

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if (out_valid !== 8'h00) $display("FAIL reset_out_valid: got %h want 00", out_valid); else n_pass++;
        n_total++; if (out_addr !== '0) $display("FAIL reset_out_addr: got %h want 0", out_addr); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (conflict_cnt !== 32'd0) $display("FAIL reset_conflict_cnt: got %0d want 0", conflict_cnt); else n_pass++;
        n_total++; if (batch_cnt !== 32'd0) $display("FAIL reset_batch_cnt: got %0d want 0", batch_cnt); else n_pass++;
        // Idle with a zero mask must never capture.
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = '0; in_addr = {8{16'h1234}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (batch_cnt !== 32'd0) $display("FAIL idle_no_capture: batch_cnt got %0d want 0", batch_cnt); else n_pass++;
        n_total++; if (out_valid !== 8'h00) $display("FAIL idle_out_valid: got %h want 00", out_valid); else n_pass++;
    endtask

    task automatic test_no_conflict;
        issue_t e;
        logic [8*AW-1:0] m;
        int first_c;
        first_c = -1;
        do_reset;
        for (int i = 0; i < 8; i++) in_addr[i*AW +: AW] = AW'(i);
        in_valid = 8'hFF;
        e.mask = 8'hFF; e.addr = in_addr; sb_q.push_back(e);
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL nc_ready_capture: got %b want 1", in_ready); else n_pass++;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            in_valid = '0;
            @(negedge clk);
            if (c == 1) begin
                n_total++; if (out_valid !== 8'h00) $display("FAIL nc_latency: out_valid at t+1 got %h want 00", out_valid); else n_pass++;
            end
            n_total++; if (in_ready !== 1'b1) $display("FAIL nc_ready: cycle %0d got %b want 1", c, in_ready); else n_pass++;
            if (out_valid != 8'h00 && out_ready) begin
                n_total++;
                if (sb_q.size() == 0) $display("FAIL nc_issue: unexpected out_valid=%h", out_valid);
                else begin
                    e = sb_q.pop_front(); m = lane_bits(e.mask);
                    $display("nc issue cycle %0d mask %h addr %h", c, out_valid, out_addr);
                    if (first_c < 0) first_c = c;
                    if (out_valid !== e.mask || (out_addr & m) !== (e.addr & m))
                        $display("FAIL nc_issue: got mask %h addr %h want mask %h addr %h", out_valid, out_addr, e.mask, e.addr & m);
                    else n_pass++;
                end
            end
        end
        n_total++; if (first_c != 2) $display("FAIL nc_first_cycle: got %0d want 2", first_c); else n_pass++;
        n_total++; if (conflict_cnt !== 32'd0) $display("FAIL nc_conflict_cnt: got %0d want 0", conflict_cnt); else n_pass++;
        n_total++; if (batch_cnt !== 32'd1) $display("FAIL nc_batch_cnt: got %0d want 1", batch_cnt); else n_pass++;
        n_total++; if (sb_q.size() != 0) $display("FAIL nc_drained: %0d issues missing want 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_all_bank0;
        issue_t e;
        logic [8*AW-1:0] m;
        int low_cnt, n_iss;
        low_cnt = 0; n_iss = 0;
        do_reset;
        for (int i = 0; i < 8; i++) in_addr[i*AW +: AW] = AW'(16'h0020 * i);
        in_valid = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            e.mask = 8'(1 << k); e.addr = in_addr; sb_q.push_back(e);
        end
        @(negedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            in_valid = '0;
            @(negedge clk);
            if (!in_ready) low_cnt++;
            if (out_valid != 8'h00 && out_ready) begin
                n_total++;
                if (sb_q.size() == 0) $display("FAIL b0_issue: unexpected out_valid=%h", out_valid);
                else begin
                    e = sb_q.pop_front(); m = lane_bits(e.mask);
                    $display("b0 issue cycle %0d mask %h", c, out_valid);
                    if (out_valid !== e.mask || (out_addr & m) !== (e.addr & m) || c != 2 + n_iss)
                        $display("FAIL b0_issue: cycle %0d got mask %h addr %h want cycle %0d mask %h addr %h", c, out_valid, out_addr & m, 2 + n_iss, e.mask, e.addr & m);
                    else n_pass++;
                    n_iss++;
                end
            end
        end
        n_total++; if (low_cnt != 7) $display("FAIL b0_ready_low: got %0d cycles want 7", low_cnt); else n_pass++;
        n_total++; if (conflict_cnt !== 32'd7) $display("FAIL b0_conflict_cnt: got %0d want 7", conflict_cnt); else n_pass++;
        n_total++; if (batch_cnt !== 32'd1) $display("FAIL b0_batch_cnt: got %0d want 1", batch_cnt); else n_pass++;
        n_total++; if (n_iss != 8) $display("FAIL b0_issue_count: got %0d want 8", n_iss); else n_pass++;
    endtask

    task automatic test_partial_conflict;
        issue_t e;
        logic [8*AW-1:0] m;
        int n_iss;
        n_iss = 0;
        do_reset;
        in_addr[0*AW +: AW] = 16'h0003;
        in_addr[1*AW +: AW] = 16'h0001;
        in_addr[2*AW +: AW] = 16'h0023;
        for (int i = 3; i < 8; i++) in_addr[i*AW +: AW] = AW'(i + 1);
        in_valid = 8'hFF;
        e.mask = 8'hFB; e.addr = in_addr; sb_q.push_back(e);
        e.mask = 8'h04; sb_q.push_back(e);
        @(negedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            in_valid = '0;
            @(negedge clk);
            if (out_valid != 8'h00 && out_ready) begin
                n_total++;
                if (sb_q.size() == 0) $display("FAIL pc_issue: unexpected out_valid=%h", out_valid);
                else begin
                    e = sb_q.pop_front(); m = lane_bits(e.mask);
                    $display("pc issue cycle %0d mask %h", c, out_valid);
                    if (out_valid !== e.mask || (out_addr & m) !== (e.addr & m))
                        $display("FAIL pc_issue: got mask %h addr %h want mask %h addr %h", out_valid, out_addr & m, e.mask, e.addr & m);
                    else n_pass++;
                    n_iss++;
                end
            end
        end
        n_total++; if (n_iss != 2) $display("FAIL pc_issue_count: got %0d want 2", n_iss); else n_pass++;
        n_total++; if (conflict_cnt !== 32'd1) $display("FAIL pc_conflict_cnt: got %0d want 1", conflict_cnt); else n_pass++;
    endtask

    task automatic test_backpressure;
        issue_t e;
        logic [8*AW-1:0] m;
        int n_iss;
        n_iss = 0;
        do_reset;
        for (int i = 0; i < 8; i++) in_addr[i*AW +: AW] = AW'(16'h0020 * i);
        in_valid = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            e.mask = 8'(1 << k); e.addr = in_addr; sb_q.push_back(e);
        end
        @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            in_valid = '0;
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                n_total++;
                if (out_valid !== 8'h02 || out_addr[1*AW +: AW] !== 16'h0020 || conflict_cnt !== 32'd2 || in_ready !== 1'b0)
                    $display("FAIL bp_hold: cycle %0d got mask %h lane1 %h cnt %0d ready %b want 02 0020 2 0", c, out_valid, out_addr[1*AW +: AW], conflict_cnt, in_ready);
                else n_pass++;
            end
            if (out_valid != 8'h00 && out_ready) begin
                n_total++;
                if (sb_q.size() == 0) $display("FAIL bp_issue: unexpected out_valid=%h", out_valid);
                else begin
                    e = sb_q.pop_front(); m = lane_bits(e.mask);
                    $display("bp issue cycle %0d mask %h", c, out_valid);
                    if (out_valid !== e.mask || (out_addr & m) !== (e.addr & m))
                        $display("FAIL bp_issue: got mask %h addr %h want mask %h addr %h", out_valid, out_addr & m, e.mask, e.addr & m);
                    else n_pass++;
                    n_iss++;
                end
            end
        end
        out_ready = 1'b1;
        n_total++; if (n_iss != 8) $display("FAIL bp_issue_count: got %0d want 8", n_iss); else n_pass++;
        n_total++; if (conflict_cnt !== 32'd7) $display("FAIL bp_conflict_cnt: got %0d want 7", conflict_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back;
        issue_t e;
        logic [8*AW-1:0] m;
        logic [8*AW-1:0] a2;
        int cap2, first2;
        bit pushed2;
        cap2 = -1; first2 = -1; pushed2 = 0;
        do_reset;
        in_addr = {8{16'hFFFF}};
        in_addr[0*AW +: AW] = 16'h0040;
        in_addr[7*AW +: AW] = 16'h0040;
        in_valid = 8'h81;
        e.mask = 8'h01; e.addr = in_addr; sb_q.push_back(e);
        e.mask = 8'h80; sb_q.push_back(e);
        a2 = '0;
        for (int i = 0; i < 4; i++) a2[i*AW +: AW] = AW'(16'h0100 + i);
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (cap2 < 0) begin
                in_valid = 8'h0F; in_addr = a2;
                if (!pushed2) begin
                    e.mask = 8'h0F; e.addr = a2; sb_q.push_back(e); pushed2 = 1;
                end
            end else in_valid = '0;
            @(negedge clk);
            if (cap2 < 0 && in_ready && in_valid != 8'h00) cap2 = c;
            if (out_valid != 8'h00 && out_ready) begin
                n_total++;
                if (sb_q.size() == 0) $display("FAIL b2b_issue: unexpected out_valid=%h", out_valid);
                else begin
                    e = sb_q.pop_front(); m = lane_bits(e.mask);
                    $display("b2b issue cycle %0d mask %h", c, out_valid);
                    if (e.mask == 8'h0F) first2 = c;
                    if (out_valid !== e.mask || (out_addr & m) !== (e.addr & m))
                        $display("FAIL b2b_issue: got mask %h addr %h want mask %h addr %h", out_valid, out_addr & m, e.mask, e.addr & m);
                    else n_pass++;
                end
            end
        end
        n_total++; if (cap2 != 2) $display("FAIL b2b_capture_cycle: got %0d want 2", cap2); else n_pass++;
        n_total++; if (first2 != 4) $display("FAIL b2b_second_issue_cycle: got %0d want 4", first2); else n_pass++;
        n_total++; if (batch_cnt !== 32'd2) $display("FAIL b2b_batch_cnt: got %0d want 2", batch_cnt); else n_pass++;
        n_total++; if (conflict_cnt !== 32'd1) $display("FAIL b2b_conflict_cnt: got %0d want 1", conflict_cnt); else n_pass++;
        n_total++; if (sb_q.size() != 0) $display("FAIL b2b_drained: %0d issues missing want 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_batch;
        issue_t e;
        logic [8*AW-1:0] m;
        int stray;
        stray = 0;
        do_reset;
        for (int i = 0; i < 8; i++) in_addr[i*AW +: AW] = AW'(16'h0020 * i);
        in_valid = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            e.mask = 8'(1 << k); e.addr = in_addr; sb_q.push_back(e);
        end
        @(negedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            in_valid = '0;
            rst = (c == 4);
            @(negedge clk);
            if (c == 5) begin
                n_total++; if (out_valid !== 8'h00) $display("FAIL rmb_out_valid: got %h want 00", out_valid); else n_pass++;
                n_total++; if (in_ready !== 1'b1) $display("FAIL rmb_in_ready: got %b want 1", in_ready); else n_pass++;
                n_total++; if (conflict_cnt !== 32'd0 || batch_cnt !== 32'd0)
                    $display("FAIL rmb_counters: got conflict %0d batch %0d want 0 0", conflict_cnt, batch_cnt); else n_pass++;
            end
            if (out_valid != 8'h00 && out_ready) begin
                if (sb_q.size() == 0) stray++;
                else begin
                    n_total++;
                    e = sb_q.pop_front(); m = lane_bits(e.mask);
                    $display("rmb issue cycle %0d mask %h", c, out_valid);
                    if (out_valid !== e.mask || (out_addr & m) !== (e.addr & m))
                        $display("FAIL rmb_issue: got mask %h addr %h want mask %h addr %h", out_valid, out_addr & m, e.mask, e.addr & m);
                    else n_pass++;
                end
            end
        end
        n_total++; if (stray != 0) $display("FAIL rmb_stray_issues: got %0d want 0", stray); else n_pass++;
        n_total++; if (sb_q.size() != 0) $display("FAIL rmb_pre_reset_issues: %0d missing want 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_no_conflict;
        test_all_bank0;
        test_partial_conflict;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_batch;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
